vaga_monitor: RTL and testbench



---
 rtl/vaga_pkg.sv | 26 ++
 rtl/spot_debounce.sv | 53 +++++
 rtl/vaga_monitor.sv | 139 +++++++++++++
 tb/tb_vaga_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vaga_pkg.sv
// Shared definitions for the parking-lot occupancy monitor: default sizing,
// the entry-gate FSM state type and a population-count helper.
package vaga_pkg;

   localparam int DEF_N_SPOTS         = 6;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;

   // Largest supported lot; popcount operates on a vector of this width.
   localparam int MAX_SPOTS = 15;

   typedef enum logic {
      IDLE         = 1'b0,
      WAIT_RELEASE = 1'b1
   } entry_state_t;

   // Number of set bits in a zero-extended occupancy vector.
   function automatic int popcount(input logic [MAX_SPOTS-1:0] v);
      int n;
      n = 0;
      for (int k = 0; k < MAX_SPOTS; k++) begin
         n += int'(v[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/spot_debounce.sv
// One spot sensor: 2-FF synchroniser followed by a stability counter. The
// output only follows the synchronised input after it has differed from the
// current output for DEBOUNCE_CYCLES consecutive cycles.
module spot_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count consecutive disagreeing cycles; flip the output on the last one.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser chain, counter and accepted output.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/vaga_monitor.sv
// Parking-lot aggregation stage: debounced per-spot occupancy, registered
// free-spot count with full/empty flags, and entry-button arbitration that
// grants a press only while a spot is free.
module vaga_monitor
   import vaga_pkg::*;
#(
   parameter  int N_SPOTS         = DEF_N_SPOTS,
   parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   localparam int CNT_W           = $clog2(N_SPOTS + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_SPOTS-1:0] sensor,
   input  logic               entry_req,
   output logic [N_SPOTS-1:0] occupied,
   output logic [CNT_W-1:0]   free_count,
   output logic               lot_full,
   output logic               lot_empty,
   output logic               count_changed,
   output logic               entry_grant,
   output logic               entry_deny
);

   logic [N_SPOTS-1:0] occupied_w;

   for (genvar i = 0; i < N_SPOTS; i++) begin : g_spot
      spot_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_spot (
         .clock  (clock),
         .reset  (reset),
         .raw    (sensor[i]),
         .stable (occupied_w[i])
      );
   end

   logic [CNT_W-1:0] free_count_q;
   logic [CNT_W-1:0] free_count_d;
   logic             lot_full_q;
   logic             lot_full_d;
   logic             lot_empty_q;
   logic             lot_empty_d;
   logic             count_changed_q;
   logic             count_changed_d;

   // Free spots and flags derived from the current debounced occupancy.
   always_comb begin
      free_count_d    = CNT_W'(N_SPOTS - popcount(MAX_SPOTS'(occupied_w)));
      lot_full_d      = (free_count_d == '0);
      lot_empty_d     = (free_count_d == CNT_W'(N_SPOTS));
      count_changed_d = (free_count_d != free_count_q);
   end

   // Count stage registers, one cycle behind occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         free_count_q    <= CNT_W'(N_SPOTS);
         lot_full_q      <= 1'b0;
         lot_empty_q     <= 1'b1;
         count_changed_q <= 1'b0;
      end else begin
         free_count_q    <= free_count_d;
         lot_full_q      <= lot_full_d;
         lot_empty_q     <= lot_empty_d;
         count_changed_q <= count_changed_d;
      end
   end

   logic       req_sync1_q;
   logic       req_sync2_q;
   logic       req_prev_q;
   logic [1:0] settle_q;
   logic [1:0] settle_d;
   logic       settled;
   logic       req_rise;

   // The synchroniser is refilled with zeros at reset, so its output cannot be
   // trusted as "released" until two cycles of real samples have arrived.
   always_comb begin
      settled  = (settle_q == 2'd2);
      settle_d = settled ? settle_q : settle_q + 2'd1;
      req_rise = req_sync2_q & ~req_prev_q;
   end

   // Entry button synchroniser, edge register and post-reset settle counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         req_sync1_q <= 1'b0;
         req_sync2_q <= 1'b0;
         req_prev_q  <= 1'b1;
         settle_q    <= 2'd0;
      end else begin
         req_sync1_q <= entry_req;
         req_sync2_q <= req_sync1_q;
         req_prev_q  <= req_sync2_q;
         settle_q    <= settle_d;
      end
   end

   entry_state_t state_q;
   logic         entry_grant_q;
   logic         entry_deny_q;

   // Entry FSM: one grant or deny per press, decided by the registered full flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= WAIT_RELEASE;
         entry_grant_q <= 1'b0;
         entry_deny_q  <= 1'b0;
      end else begin
         entry_grant_q <= 1'b0;
         entry_deny_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_rise) begin
                  entry_grant_q <= ~lot_full_q;
                  entry_deny_q  <= lot_full_q;
                  state_q       <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (settled && !req_sync2_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= WAIT_RELEASE;
         endcase
      end
   end

   assign occupied      = occupied_w;
   assign free_count    = free_count_q;
   assign lot_full      = lot_full_q;
   assign lot_empty     = lot_empty_q;
   assign count_changed = count_changed_q;
   assign entry_grant   = entry_grant_q;
   assign entry_deny    = entry_deny_q;

endmodule

// File: tb/tb_vaga_monitor.sv
// Bench for vaga_monitor with a short debounce window.
module tb_vaga_monitor;

   localparam int N  = 6;
   localparam int D  = 4;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  sensor = '0;
   logic          entry_req = 1'b0;
   logic [N-1:0]  occupied;
   logic [CW-1:0] free_count;
   logic          lot_full;
   logic          lot_empty;
   logic          count_changed;
   logic          entry_grant;
   logic          entry_deny;

   vaga_monitor #(
      .N_SPOTS(N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .sensor        (sensor),
      .entry_req     (entry_req),
      .occupied      (occupied),
      .free_count    (free_count),
      .lot_full      (lot_full),
      .lot_empty     (lot_empty),
      .count_changed (count_changed),
      .entry_grant   (entry_grant),
      .entry_deny    (entry_deny)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: a spot's accepted value flips once its synchronised
   // input has disagreed with it over the whole most recent window of D cycles.
   logic [N-1:0] m_s1  = '0;
   logic [N-1:0] m_s2  = '0;
   logic [N-1:0] m_occ = '0;
   logic [D-1:0] m_win [N];
   int           m_fill  = 0;
   int           m_free  = N;
   bit           m_full  = 1'b0;
   bit           m_empty = 1'b1;
   bit           m_chg   = 1'b0;

   int chg_seen   = 0;
   int grant_seen = 0;
   int deny_seen  = 0;

   typedef struct {
      logic [N-1:0] pat;
      int           exp_free;
      bit           exp_full;
      bit           exp_empty;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic [N-1:0] x);
      logic [N-1:0] occ_n;
      int           fc;
      if (rst) begin
         m_s1    = '0;
         m_s2    = '0;
         m_occ   = '0;
         m_free  = N;
         m_full  = 1'b0;
         m_empty = 1'b1;
         m_chg   = 1'b0;
         for (int i = 0; i < N; i++) m_win[i] = '0;
         m_fill = 1;
      end else begin
         fc      = N - $countones(m_occ);
         m_chg   = (fc != m_free);
         m_free  = fc;
         m_full  = (fc == 0);
         m_empty = (fc == N);
         occ_n   = m_occ;
         for (int i = 0; i < N; i++) begin
            if (m_fill >= D && m_win[i] == {D{~m_occ[i]}}) occ_n[i] = ~m_occ[i];
         end
         m_occ = occ_n;
         m_s2  = m_s1;
         m_s1  = x;
         for (int i = 0; i < N; i++) m_win[i] = {m_win[i][D-2:0], m_s2[i]};
         if (m_fill < D) m_fill++;
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clock);
      #1;
      model_step(reset, sensor);
      check("occupied", occupied, m_occ);
      check("free_count", free_count, m_free);
      check("lot_full", lot_full, m_full);
      check("lot_empty", lot_empty, m_empty);
      check("count_changed", count_changed, m_chg);
      check("grant_deny_excl", entry_grant & entry_deny, 0);
      chg_seen   += int'(count_changed);
      grant_seen += int'(entry_grant);
      deny_seen  += int'(entry_deny);
   endtask

   initial begin
      int pflip;
      for (int i = 0; i < N; i++) m_win[i] = '0;

      vecs[0] = '{6'b000000, 6, 1'b0, 1'b1};
      vecs[1] = '{6'b101010, 3, 1'b0, 1'b0};
      vecs[2] = '{6'b111111, 0, 1'b1, 1'b0};
      vecs[3] = '{6'b011111, 1, 1'b0, 1'b0};
      vecs[4] = '{6'b000001, 5, 1'b0, 1'b0};
      vecs[5] = '{6'b110000, 4, 1'b0, 1'b0};
      vecs[6] = '{6'b000111, 3, 1'b0, 1'b0};

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chg_seen = 0; grant_seen = 0; deny_seen = 0;
      repeat (6) tick();
      check("rst_occupied", occupied, 0);
      check("rst_free", free_count, 6);
      check("rst_full", lot_full, 0);
      check("rst_empty", lot_empty, 1);
      check("rst_pulses", chg_seen + grant_seen + deny_seen, 0);

      // Short glitch must be filtered
      chg_seen = 0;
      sensor[2] = 1'b1;
      repeat (3) tick();
      sensor[2] = 1'b0;
      repeat (10) tick();
      check("glitch_occ", occupied, 0);
      check("glitch_free", free_count, 6);
      check("glitch_chg", chg_seen, 0);

      // Held sensor: accepted exactly 6 cycles after the change
      sensor[0] = 1'b1;
      repeat (5) tick();
      check("lat5_occ0", occupied[0], 0);
      tick();
      check("lat6_occ0", occupied[0], 1);
      check("lat6_free", free_count, 6);
      tick();
      check("lat7_free", free_count, 5);
      check("lat7_chg", count_changed, 1);
      check("lat7_empty", lot_empty, 0);
      tick();
      check("lat8_chg", count_changed, 0);

      // All spots at once: one recomputation, lot full
      chg_seen = 0;
      sensor = 6'b111111;
      repeat (12) tick();
      check("full_chg_once", chg_seen, 1);
      check("full_free", free_count, 0);
      check("full_flag", lot_full, 1);

      // Press while full is denied
      grant_seen = 0; deny_seen = 0;
      entry_req = 1'b1;
      repeat (2) tick();
      check("deny_early", entry_deny, 0);
      tick();
      check("deny_pulse", entry_deny, 1);
      check("deny_no_grant", entry_grant, 0);
      repeat (10) tick();
      entry_req = 1'b0;
      repeat (6) tick();
      check("deny_count", deny_seen, 1);
      check("deny_grant_count", grant_seen, 0);

      // Table of occupancy patterns
      foreach (vecs[v]) begin
         sensor = vecs[v].pat;
         repeat (10) tick();
         check("tbl_occ", occupied, vecs[v].pat);
         check("tbl_free", free_count, vecs[v].exp_free);
         check("tbl_full", lot_full, vecs[v].exp_full);
         check("tbl_empty", lot_empty, vecs[v].exp_empty);
      end

      // Held button yields one grant, three cycles after the press
      grant_seen = 0; deny_seen = 0;
      entry_req = 1'b1;
      repeat (2) tick();
      check("grant_early", entry_grant, 0);
      tick();
      check("grant_pulse", entry_grant, 1);
      repeat (17) tick();
      entry_req = 1'b0;
      repeat (6) tick();
      check("grant_count", grant_seen, 1);
      grant_seen = 0;
      entry_req = 1'b1;
      repeat (3) tick();
      check("grant2_pulse", entry_grant, 1);
      repeat (4) tick();
      entry_req = 1'b0;
      repeat (6) tick();
      check("grant2_count", grant_seen, 1);
      check("grant_deny_count", deny_seen, 0);

      // Button and sensor held through reset
      sensor = 6'b000010;
      entry_req = 1'b1;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      grant_seen = 0;
      repeat (5) tick();
      check("rst_lat5_occ1", occupied[1], 0);
      tick();
      check("rst_lat6_occ1", occupied[1], 1);
      repeat (20) tick();
      check("held_no_grant", grant_seen, 0);
      entry_req = 1'b0;
      repeat (5) tick();
      entry_req = 1'b1;
      repeat (3) tick();
      check("repress_grant", entry_grant, 1);
      repeat (3) tick();
      entry_req = 1'b0;
      repeat (6) tick();
      check("repress_count", grant_seen, 1);

      // Random sensor activity with occasional resets
      pflip = 5;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) pflip = $urandom_range(2, 12);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, pflip - 1) == 0) sensor[i] = ~sensor[i];
         end
         reset = ($urandom_range(0, 499) == 0);
         tick();
         check("rand_no_pulse", entry_grant | entry_deny, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
